// File: rtl/us_mac_tx_pkg.sv
// us_mac_tx_pkg: shared types and helpers for the MAC TX arbiter/padder.
// Padding is built only when US_MAC_TX_PAD_EN is defined.
package us_mac_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_PAD  = 2'd2
   } tx_state_t;

   // Ethernet minimum frame length without FCS.
   localparam int MIN_FRAME_BYTES_DFLT = 60;

   // Number of valid bytes in a low-aligned tkeep mask.
   function automatic logic [3:0] keep_to_cnt(input logic [7:0] keep);
      logic [3:0] cnt;
      cnt = '0;
      for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, keep[i]};
      return cnt;
   endfunction

   // Low-aligned tkeep mask covering cnt bytes.
   function automatic logic [7:0] cnt_to_keep(input logic [3:0] cnt);
      logic [7:0] mask;
      mask = '0;
      for (int i = 0; i < 8; i++) if (4'(i) < cnt) mask[i] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/us_mac_tx_pad.sv
// us_mac_tx_pad: combinational per-beat pad/zero datapath.
// A short tlast beat gets its unused bytes zeroed; it either closes the
// frame at the minimum length or signals that pad beats must follow.
module us_mac_tx_pad
   import us_mac_tx_pkg::*;
#(
   parameter int MIN_FRAME_BYTES = MIN_FRAME_BYTES_DFLT
)(
   input  logic [3:0]  beat_idx,
   input  logic [63:0] tdata,
   input  logic [7:0]  tkeep,
   input  logic        tlast,
   output logic [63:0] pad_tdata,
   output logic [7:0]  pad_tkeep,
   output logic        pad_tlast,
   output logic        need_pad
);

   localparam int         MIN_BEATS = (MIN_FRAME_BYTES + 7) / 8;
   localparam logic [3:0] LAST_IDX  = 4'(MIN_BEATS - 1);
   localparam logic [7:0] MIN_BYTES = 8'(MIN_FRAME_BYTES);
   localparam logic [7:0] LAST_KEEP = cnt_to_keep(4'(((MIN_FRAME_BYTES - 1) % 8) + 1));

   logic [7:0]  total;
   logic        short_frm;
   logic [63:0] zeroed;

   // beat_idx saturates at MIN_BEATS, so 8 bits never overflow here
   assign total     = {1'b0, beat_idx, 3'b000} + {4'b0000, keep_to_cnt(tkeep)};
   assign short_frm = tlast && (total < MIN_BYTES);

   genvar i;
   generate
      for (i = 0; i < 8; i++) begin : g_byte
         assign zeroed[8*i +: 8] = tkeep[i] ? tdata[8*i +: 8] : 8'h00;
      end
   endgenerate

   // Rewrite a short last beat; everything else passes untouched.
   always_comb begin
      pad_tdata = tdata;
      pad_tkeep = tkeep;
      pad_tlast = tlast;
      need_pad  = 1'b0;
      if (short_frm) begin
         pad_tdata = zeroed;
         if (beat_idx == LAST_IDX) begin
            pad_tkeep = LAST_KEEP;
            pad_tlast = 1'b1;
         end else begin
            pad_tkeep = 8'hFF;
            pad_tlast = 1'b0;
            need_pad  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/us_mac_tx_arb.sv
// us_mac_tx_arb: frame-level round-robin merge of the ARP and IP TX streams
// into one registered MAC TX stream, zero-padding runts to the Ethernet
// minimum. Padding (PAD state, byte zeroing) exists only with
// US_MAC_TX_PAD_EN defined; otherwise frames are forwarded unchanged.
module us_mac_tx_arb
   import us_mac_tx_pkg::*;
#(
   parameter int MIN_FRAME_BYTES = MIN_FRAME_BYTES_DFLT
)(
   input  logic        tx_axis_aclk,
   input  logic        tx_axis_aresetn,
   input  logic [63:0] arp_tx_axis_tdata,
   input  logic [7:0]  arp_tx_axis_tkeep,
   input  logic        arp_tx_axis_tvalid,
   input  logic        arp_tx_axis_tlast,
   output logic        arp_tx_axis_tready,
   input  logic [63:0] ip_tx_axis_tdata,
   input  logic [7:0]  ip_tx_axis_tkeep,
   input  logic        ip_tx_axis_tvalid,
   input  logic        ip_tx_axis_tlast,
   output logic        ip_tx_axis_tready,
   output logic [63:0] mac_tx_axis_tdata,
   output logic [7:0]  mac_tx_axis_tkeep,
   output logic        mac_tx_axis_tvalid,
   output logic        mac_tx_axis_tlast,
   input  logic        mac_tx_axis_tready,
   output logic [1:0]  tx_grant,
   output logic        tx_busy
);

   localparam int         MIN_BEATS = (MIN_FRAME_BYTES + 7) / 8;
   localparam logic [3:0] SAT_IDX   = 4'(MIN_BEATS);
`ifdef US_MAC_TX_PAD_EN
   localparam logic [3:0] LAST_IDX  = 4'(MIN_BEATS - 1);
   localparam logic [7:0] LAST_KEEP = cnt_to_keep(4'(((MIN_FRAME_BYTES - 1) % 8) + 1));
`endif

   tx_state_t   state, state_nxt;
   logic [1:0]  grant, grant_nxt;
   logic        last_owner, last_owner_nxt;   // 0 = ARP, 1 = IP
   logic [3:0]  beat_idx, beat_idx_nxt;

   logic [63:0] sel_tdata;
   logic [7:0]  sel_tkeep;
   logic        sel_tvalid, sel_tlast;
   logic [63:0] beat_tdata;
   logic [7:0]  beat_tkeep;
   logic        beat_tlast;
`ifdef US_MAC_TX_PAD_EN
   logic        need_pad;
`endif

   logic        out_free, accept, load;
   logic [63:0] ld_tdata;
   logic [7:0]  ld_tkeep;
   logic        ld_tlast;

   assign out_free = !mac_tx_axis_tvalid || mac_tx_axis_tready;

   assign arp_tx_axis_tready = grant[0] && (state == ST_PASS) && out_free;
   assign ip_tx_axis_tready  = grant[1] && (state == ST_PASS) && out_free;

   assign sel_tdata  = grant[1] ? ip_tx_axis_tdata  : arp_tx_axis_tdata;
   assign sel_tkeep  = grant[1] ? ip_tx_axis_tkeep  : arp_tx_axis_tkeep;
   assign sel_tvalid = grant[1] ? ip_tx_axis_tvalid : arp_tx_axis_tvalid;
   assign sel_tlast  = grant[1] ? ip_tx_axis_tlast  : arp_tx_axis_tlast;

   assign accept   = (state == ST_PASS) && sel_tvalid && out_free;
   assign tx_grant = grant;
   assign tx_busy  = (state != ST_IDLE);

`ifdef US_MAC_TX_PAD_EN
   us_mac_tx_pad #(
      .MIN_FRAME_BYTES (MIN_FRAME_BYTES)
   ) u_pad (
      .beat_idx  (beat_idx),
      .tdata     (sel_tdata),
      .tkeep     (sel_tkeep),
      .tlast     (sel_tlast),
      .pad_tdata (beat_tdata),
      .pad_tkeep (beat_tkeep),
      .pad_tlast (beat_tlast),
      .need_pad  (need_pad)
   );
`else
   assign beat_tdata = sel_tdata;
   assign beat_tkeep = sel_tkeep;
   assign beat_tlast = sel_tlast;
`endif

   // Arbitration and frame sequencing; decides what loads the output register.
   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_owner_nxt = last_owner;
      beat_idx_nxt   = beat_idx;
      load           = 1'b0;
      ld_tdata       = beat_tdata;
      ld_tkeep       = beat_tkeep;
      ld_tlast       = beat_tlast;
      case (state)
         ST_IDLE: begin
            beat_idx_nxt = '0;
            // ARP wins a tie unless it owned the previous frame
            if (arp_tx_axis_tvalid && (!ip_tx_axis_tvalid || last_owner)) begin
               grant_nxt = 2'b01;
               state_nxt = ST_PASS;
            end else if (ip_tx_axis_tvalid) begin
               grant_nxt = 2'b10;
               state_nxt = ST_PASS;
            end
         end
         ST_PASS: begin
            if (accept) begin
               load = 1'b1;
               if (beat_idx != SAT_IDX) beat_idx_nxt = beat_idx + 4'd1;
               if (sel_tlast) begin
                  last_owner_nxt = grant[1];
`ifdef US_MAC_TX_PAD_EN
                  if (need_pad) begin
                     state_nxt = ST_PAD;
                  end else begin
                     state_nxt = ST_IDLE;
                     grant_nxt = 2'b00;
                  end
`else
                  state_nxt = ST_IDLE;
                  grant_nxt = 2'b00;
`endif
               end
            end
         end
`ifdef US_MAC_TX_PAD_EN
         ST_PAD: begin
            if (out_free) begin
               load         = 1'b1;
               ld_tdata     = '0;
               beat_idx_nxt = beat_idx + 4'd1;
               if (beat_idx == LAST_IDX) begin
                  ld_tkeep  = LAST_KEEP;
                  ld_tlast  = 1'b1;
                  state_nxt = ST_IDLE;
                  grant_nxt = 2'b00;
               end else begin
                  ld_tkeep  = 8'hFF;
                  ld_tlast  = 1'b0;
               end
            end
         end
`endif
         default: begin
            state_nxt = ST_IDLE;
            grant_nxt = 2'b00;
         end
      endcase
   end

   // Control state registers.
   always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
      if (!tx_axis_aresetn) begin
         state      <= ST_IDLE;
         grant      <= 2'b00;
         last_owner <= 1'b1;
         beat_idx   <= '0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_owner <= last_owner_nxt;
         beat_idx   <= beat_idx_nxt;
      end
   end

   // Output register: loads when free, holds under backpressure.
   always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
      if (!tx_axis_aresetn) begin
         mac_tx_axis_tdata  <= '0;
         mac_tx_axis_tkeep  <= '0;
         mac_tx_axis_tlast  <= 1'b0;
         mac_tx_axis_tvalid <= 1'b0;
      end else if (load) begin
         mac_tx_axis_tdata  <= ld_tdata;
         mac_tx_axis_tkeep  <= ld_tkeep;
         mac_tx_axis_tlast  <= ld_tlast;
         mac_tx_axis_tvalid <= 1'b1;
      end else if (mac_tx_axis_tready) begin
         mac_tx_axis_tvalid <= 1'b0;
      end
   end

endmodule
